vector_frame_parser: RTL

- Consumes the byte stream from the UART receiver: one byte per o_Rx_DV-style strobe.
- Hunts for a sync preamble of consecutive 0x00 bytes, then assembles 4-byte big-endian command words.
- Recognises an end-of-frame marker word and signals it.
- Buffers command words in a small FIFO with valid/ready handshake toward the vector draw engine. The UART cannot be stalled, so overflow drops words and sets a sticky flag.

---
 rtl/vector_frame_parser.sv | 130 +++++++++++++
 1 files changed

// File: rtl/vector_frame_parser.sv
// Byte-stream frame parser: hunts a zero-byte preamble, assembles big-endian
// 32-bit command words and queues them in a small FWFT FIFO for the draw engine.
module vector_frame_parser #(
    parameter int unsigned SYNC_LEN   = 8,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [31:0] EOF_WORD   = 32'h01010101
) (
    input  logic        i_Clock,
    input  logic        i_Rst_n,
    input  logic        i_Rx_DV,
    input  logic [7:0]  i_Rx_Byte,
    output logic [31:0] o_Word,
    output logic        o_Word_Valid,
    input  logic        i_Word_Ready,
    output logic        o_Frame_Start,
    output logic        o_Frame_End,
    output logic        o_Overflow,
    output logic        o_In_Frame
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    typedef enum logic {HUNT, FRAME} state_t;

    state_t        state;
    logic [7:0]    zero_cnt;
    logic [1:0]    byte_idx;
    logic [23:0]   shift_p0;
    logic [31:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;

    logic [31:0]   word_p0;
    logic          word_done;
    logic          is_eof;
    logic          push;
    logic          pop;
    logic          full;
    logic          push_ok;
    logic          drop;
    logic [AW:0]   count_nxt;
    logic [AW-1:0] rd_nxt;
    logic [31:0]   head_nxt;

    always_comb begin
        word_p0   = {shift_p0, i_Rx_Byte};
        word_done = i_Rx_DV && (state == FRAME) && (byte_idx == 2'd3);
        is_eof    = word_done && (word_p0 == EOF_WORD);
        push      = word_done && (word_p0 != EOF_WORD);
        pop       = o_Word_Valid && i_Word_Ready;
        full      = (count == (AW+1)'(FIFO_DEPTH));
        // A pop frees the slot this cycle, so a push at full still fits.
        push_ok   = push && (!full || pop);
        drop      = push && full && !pop;
        count_nxt = count + (AW+1)'(push_ok) - (AW+1)'(pop);
        rd_nxt    = pop ? rd_ptr + 1'b1 : rd_ptr;
        // Bypass the memory when the new word becomes the head immediately.
        if (push_ok && (rd_nxt == wr_ptr))
            head_nxt = word_p0;
        else
            head_nxt = mem[rd_nxt];
    end

    // Stage p0: byte assembly and FIFO storage (data only)
    always_ff @(posedge i_Clock) begin
        if (i_Rx_DV && (state == FRAME))
            shift_p0 <= word_p0[23:0];
        if (push_ok)
            mem[wr_ptr] <= word_p0;
    end

    always_ff @(posedge i_Clock) begin
        if (!i_Rst_n) begin
            state         <= HUNT;
            zero_cnt      <= 8'd0;
            byte_idx      <= 2'd0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            o_Word        <= 32'd0;
            o_Word_Valid  <= 1'b0;
            o_Frame_Start <= 1'b0;
            o_Frame_End   <= 1'b0;
            o_Overflow    <= 1'b0;
            o_In_Frame    <= 1'b0;
        end else begin
            o_Frame_Start <= 1'b0;
            o_Frame_End   <= 1'b0;
            if (i_Rx_DV) begin
                case (state)
                    HUNT: begin
                        if (i_Rx_Byte == 8'h00) begin
                            if (zero_cnt == 8'(SYNC_LEN - 1)) begin
                                state         <= FRAME;
                                zero_cnt      <= 8'd0;
                                byte_idx      <= 2'd0;
                                o_Frame_Start <= 1'b1;
                                o_In_Frame    <= 1'b1;
                            end else begin
                                zero_cnt <= zero_cnt + 8'd1;
                            end
                        end else begin
                            zero_cnt <= 8'd0;
                        end
                    end
                    FRAME: begin
                        byte_idx <= byte_idx + 2'd1;
                        if (is_eof) begin
                            state       <= HUNT;
                            zero_cnt    <= 8'd0;
                            o_Frame_End <= 1'b1;
                            o_In_Frame  <= 1'b0;
                        end
                    end
                endcase
            end
            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;
            rd_ptr       <= rd_nxt;
            count        <= count_nxt;
            o_Word_Valid <= (count_nxt != '0);
            if (count_nxt != '0)
                o_Word <= head_nxt;
            if (drop)
                o_Overflow <= 1'b1;
        end
    end

endmodule
